button_event_decoder: RTL and testbench

Classifies debounced button presses into single-press and double-press events. Sits downstream of the button debouncer in the clk_1M domain, consuming its one-pulse-per-press output. Emits one-cycle event strobes and a running event count for the lab control logic. A press followed by a second press within a programmable window is a double; otherwise it is a single.

---
 rtl/button_event_decoder_if.sv | 24 ++
 rtl/button_event_decoder.sv | 81 ++++++++
 tb/tb_button_event_decoder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/button_event_decoder_if.sv
// Button event decoder port bundle: debounced button level in, event strobes, busy flag and count out.
interface button_event_decoder_if;
   logic       btn_db;
   logic       single_press;
   logic       double_press;
   logic       busy;
   logic [7:0] evt_count;

   modport master (
      output btn_db,
      input  single_press,
      input  double_press,
      input  busy,
      input  evt_count
   );

   modport slave (
      input  btn_db,
      output single_press,
      output double_press,
      output busy,
      output evt_count
   );
endinterface

// File: rtl/button_event_decoder.sv
// Decodes debounced press edges into single/double press strobes using a
// programmable double-press window, and keeps a wrapping event count.
module button_event_decoder #(
   parameter logic [21:0] DBL_WINDOW = 22'd400000
) (
   input  logic                  clk_1M,
   input  logic                  rst,
   button_event_decoder_if.slave bus
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t      state, state_nxt;
   logic [21:0] timer, timer_nxt;
   logic        prev;
   logic        single_q, double_q;
   logic        single_nxt, double_nxt;
   logic [7:0]  evt_count_q;
   logic        press;

   assign press = bus.btn_db & ~prev;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      single_nxt = 1'b0;
      double_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (press) begin
               timer_nxt = DBL_WINDOW;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // A press on the last window cycle still counts as a double.
            if (press) begin
               double_nxt = 1'b1;
               state_nxt  = S_IDLE;
            end else if (timer == 22'd1) begin
               single_nxt = 1'b1;
               state_nxt  = S_IDLE;
            end else begin
               timer_nxt = timer - 22'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_1M) begin
      if (rst) begin
         state       <= S_IDLE;
         timer       <= '0;
         prev        <= 1'b1;  // a button held through reset is not a press
         single_q    <= 1'b0;
         double_q    <= 1'b0;
         evt_count_q <= '0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         prev     <= bus.btn_db;
         single_q <= single_nxt;
         double_q <= double_nxt;
         if (single_nxt || double_nxt) begin
            evt_count_q <= evt_count_q + 8'd1;
         end
      end
   end

   assign bus.single_press = single_q;
   assign bus.double_press = double_q;
   assign bus.busy         = (state == S_WAIT);
   assign bus.evt_count    = evt_count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: vector table, directed window/reset cases,
// and random button activity compared against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_button_event_decoder;

   localparam int W = 20;

   logic clk_1M = 1'b0;
   logic rst    = 1'b1;

   button_event_decoder_if dif ();

   button_event_decoder #(.DBL_WINDOW(22'(W))) dut (
      .clk_1M (clk_1M),
      .rst    (rst),
      .bus    (dif.slave)
   );

   always #500 clk_1M = ~clk_1M;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: remembers when the pending press happened and decides by elapsed time.
   longint cyc       = 0;
   longint m_start   = 0;
   bit     m_pending = 1'b0;
   bit     m_prev    = 1'b1;
   bit     m_single  = 1'b0;
   bit     m_double  = 1'b0;
   int     m_count   = 0;

   always @(posedge clk_1M) begin
      bit pressed;
      m_single = 1'b0;
      m_double = 1'b0;
      if (rst) begin
         m_pending = 1'b0;
         m_prev    = 1'b1;
         m_count   = 0;
      end else begin
         pressed = dif.btn_db && !m_prev;
         if (m_pending) begin
            if (pressed) begin
               m_double  = 1'b1;
               m_pending = 1'b0;
            end else if (cyc - m_start == longint'(W)) begin
               m_single  = 1'b1;
               m_pending = 1'b0;
            end
         end else if (pressed) begin
            m_pending = 1'b1;
            m_start   = cyc;
         end
         if (m_single || m_double) m_count = (m_count + 1) % 256;
         m_prev = dif.btn_db;
      end
      cyc++;
   end

   bit chk_en = 1'b0;

   always @(negedge clk_1M) begin
      if (chk_en) begin
         check("model single_press", 32'(dif.single_press), 32'(m_single));
         check("model double_press", 32'(dif.double_press), 32'(m_double));
         check("model busy", 32'(dif.busy), 32'(m_pending));
         check("model evt_count", 32'(dif.evt_count), 32'(m_count));
         check("strobes exclusive", 32'(dif.single_press & dif.double_press), 32'd0);
      end
   end

   // One rising clock edge with the given inputs; returns on the following falling edge.
   task automatic step(input logic r, input logic b);
      rst        = r;
      dif.btn_db = b;
      @(posedge clk_1M);
      @(negedge clk_1M);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   typedef struct packed {
      logic       r;
      logic       b;
      logic       s;
      logic       d;
      logic       busy;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic b, input logic s,
                               input logic d, input logic bz, input logic [7:0] c);
      vecs.push_back('{r: r, b: b, s: s, d: d, busy: bz, cnt: c});
   endfunction

   initial begin
      int run;
      logic lvl;

      dif.btn_db = 1'b1;

      // Startup with the button held, then a double press with edges 8 cycles apart.
      for (int i = 0; i < 3; i++)  add(1, 1, 0, 0, 0, 8'd0);
      for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, 8'd0);
      for (int i = 0; i < 2; i++)  add(0, 0, 0, 0, 0, 8'd0);
      add(0, 1, 0, 0, 1, 8'd0);
      for (int i = 0; i < 7; i++)  add(0, 0, 0, 0, 1, 8'd0);
      add(0, 1, 0, 1, 0, 8'd1);
      add(0, 0, 0, 0, 0, 8'd1);
      add(0, 0, 0, 0, 0, 8'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].r, vecs[i].b);
         chk_en = 1'b1;
         check($sformatf("vec%0d single_press", i), 32'(dif.single_press), 32'(vecs[i].s));
         check($sformatf("vec%0d double_press", i), 32'(dif.double_press), 32'(vecs[i].d));
         check($sformatf("vec%0d busy", i), 32'(dif.busy), 32'(vecs[i].busy));
         check($sformatf("vec%0d evt_count", i), 32'(dif.evt_count), 32'(vecs[i].cnt));
      end

      // Single press: 5-cycle pulse, strobe only after posedge k+W.
      do_reset();
      for (int m = 0; m <= W + 1; m++) begin
         step(1'b0, (m < 5) ? 1'b1 : 1'b0);
         check($sformatf("single m=%0d single_press", m), 32'(dif.single_press), (m == W) ? 32'd1 : 32'd0);
         check($sformatf("single m=%0d busy", m), 32'(dif.busy), (m < W) ? 32'd1 : 32'd0);
      end
      check("single evt_count", 32'(dif.evt_count), 32'd1);

      // Second edge exactly on posedge k+W is still a double.
      do_reset();
      step(1'b0, 1'b1);
      for (int m = 1; m < W; m++) step(1'b0, 1'b0);
      check("boundary busy before", 32'(dif.busy), 32'd1);
      step(1'b0, 1'b1);
      check("boundary W double_press", 32'(dif.double_press), 32'd1);
      check("boundary W single_press", 32'(dif.single_press), 32'd0);
      step(1'b0, 1'b0);
      check("boundary W evt_count", 32'(dif.evt_count), 32'd1);

      // Second edge at k+W+1: single first, then a fresh sequence.
      do_reset();
      step(1'b0, 1'b1);
      for (int m = 1; m <= W; m++) step(1'b0, 1'b0);
      check("late single_press", 32'(dif.single_press), 32'd1);
      step(1'b0, 1'b1);
      check("late new seq busy", 32'(dif.busy), 32'd1);
      check("late new seq single_press", 32'(dif.single_press), 32'd0);
      for (int m = W + 2; m <= 2 * W + 1; m++) step(1'b0, 1'b0);
      check("late second single_press", 32'(dif.single_press), 32'd1);
      check("late evt_count", 32'(dif.evt_count), 32'd2);

      // Reset mid-WAIT drops the pending press.
      do_reset();
      step(1'b0, 1'b1);
      for (int m = 1; m < 5; m++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check("midreset busy", 32'(dif.busy), 32'd0);
      for (int m = 0; m < W + 5; m++) begin
         step(1'b0, 1'b0);
         check("midreset no strobe", 32'(dif.single_press | dif.double_press), 32'd0);
      end
      check("midreset evt_count", 32'(dif.evt_count), 32'd0);

      // Random button activity with occasional resets.
      do_reset();
      run = 0;
      lvl = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (run == 0) begin
            lvl = ~lvl;
            run = $urandom_range(1, 28);
         end
         run--;
         step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, lvl);
      end

      // 257 isolated single presses wrap the count to 1.
      do_reset();
      for (int p = 0; p < 257; p++) begin
         step(1'b0, 1'b1);
         for (int m = 0; m < W + 1; m++) step(1'b0, 1'b0);
      end
      check("wrap evt_count", 32'(dif.evt_count), 32'd1);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
